// File: rtl/reg_file_sb.sv
// Parametrised register file with two bypassable read ports and one debug read port.
// A per-register busy scoreboard tracks in-flight writes for the control unit.
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    localparam int NREG    = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              load,
    input  logic [ADDR_W-1:0] Caddr,
    input  logic [DATA_W-1:0] C,
    input  logic [ADDR_W-1:0] Aaddr,
    input  logic [ADDR_W-1:0] Baddr,
    input  logic [ADDR_W-1:0] Daddr,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] Dout,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] Raddr,
    output logic              busy_A,
    output logic              busy_B,
    output logic              rsv_conflict,
    output logic [NREG-1:0]   busy_vec
);

    logic [DATA_W-1:0] mem [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic              wr_en;
    logic              rsv_ok;
    logic              byp_a;
    logic              byp_b;

    function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    assign wr_en  = load && !is_zero(Caddr);
    assign rsv_ok = reserve && !is_zero(Raddr);
    assign byp_a  = (BYPASS != 0) && wr_en && (Caddr == Aaddr);
    assign byp_b  = (BYPASS != 0) && wr_en && (Caddr == Baddr);

    // Writeback frees the register first; a reserve only succeeds on the pre-edge free state.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        busy_nxt = busy;
        if (load)
            busy_nxt[Caddr] = 1'b0;
        if (rsv_ok && !busy[Raddr])
            busy_nxt[Raddr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            // NOTE: the array is flushed on clear, so it maps to flops rather than a RAM macro.
            for (int i = 0; i < NREG; i++)
                mem[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_en)
                mem[Caddr] <= C;
            busy <= busy_nxt;
        end
    end

    always_comb begin
        A      = is_zero(Aaddr) ? '0 : mem[Aaddr];
        B      = is_zero(Baddr) ? '0 : mem[Baddr];
        Dout   = is_zero(Daddr) ? '0 : mem[Daddr];
        busy_A = busy[Aaddr];
        busy_B = busy[Baddr];
        if (byp_a) begin
            A      = C;
            busy_A = 1'b0;
        end
        if (byp_b) begin
            B      = C;
            busy_B = 1'b0;
        end
    end

    assign rsv_conflict = rsv_ok && busy[Raddr];
    assign busy_vec     = busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: instance 0 uses ZERO_REG=0/BYPASS=1, instance 1 uses
// ZERO_REG=1/BYPASS=0; both share stimulus and are compared against an array-based model.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        clear, load, reserve;
    logic [3:0]  Caddr, Aaddr, Baddr, Daddr, Raddr;
    logic [15:0] C;

    logic [15:0] a0, b0, d0, bv0;
    logic        ba0, bb0, rc0;
    logic [15:0] a1, b1, d1, bv1;
    logic        ba1, bb1, rc1;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_mem  [2][16];
    logic [15:0] m_busy [2];

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) dut0 (
        .clk(clk), .clear(clear), .load(load), .Caddr(Caddr), .C(C),
        .Aaddr(Aaddr), .Baddr(Baddr), .Daddr(Daddr), .A(a0), .B(b0), .Dout(d0),
        .reserve(reserve), .Raddr(Raddr), .busy_A(ba0), .busy_B(bb0),
        .rsv_conflict(rc0), .busy_vec(bv0)
    );

    reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) dut1 (
        .clk(clk), .clear(clear), .load(load), .Caddr(Caddr), .C(C),
        .Aaddr(Aaddr), .Baddr(Baddr), .Daddr(Daddr), .A(a1), .B(b1), .Dout(d1),
        .reserve(reserve), .Raddr(Raddr), .busy_A(ba1), .busy_B(bb1),
        .rsv_conflict(rc1), .busy_vec(bv1)
    );

    // Model: instance k has a hardwired zero register when k==1 and bypass when k==0.
    function automatic logic m_zero(input int k, input logic [3:0] a);
        return (k == 1) && (a == 4'd0);
    endfunction

    function automatic logic m_byp(input int k, input logic [3:0] a);
        return (k == 0) && load && (Caddr == a) && !m_zero(k, Caddr);
    endfunction

    function automatic logic [15:0] m_rd(input int k, input logic [3:0] a);
        return m_zero(k, a) ? 16'h0 : m_mem[k][a];
    endfunction

    function automatic logic [66:0] m_exp(input int k);
        logic [15:0] ea, eb, ed;
        logic        eba, ebb, erc;
        ea  = m_byp(k, Aaddr) ? C : m_rd(k, Aaddr);
        eb  = m_byp(k, Baddr) ? C : m_rd(k, Baddr);
        ed  = m_rd(k, Daddr);
        eba = m_byp(k, Aaddr) ? 1'b0 : m_busy[k][Aaddr];
        ebb = m_byp(k, Baddr) ? 1'b0 : m_busy[k][Baddr];
        erc = reserve && !m_zero(k, Raddr) && m_busy[k][Raddr];
        return {ea, eb, ed, eba, ebb, erc, m_busy[k]};
    endfunction

    task automatic tick();
        logic was_busy;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (clear) begin
                for (int i = 0; i < 16; i++) m_mem[k][i] = 16'h0;
                m_busy[k] = 16'h0;
            end else begin
                was_busy = m_busy[k][Raddr];
                if (load && !m_zero(k, Caddr)) m_mem[k][Caddr] = C;
                if (load) m_busy[k][Caddr] = 1'b0;
                if (reserve && !m_zero(k, Raddr) && !was_busy) m_busy[k][Raddr] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle();
        clear = 1'b0; load = 1'b0; reserve = 1'b0;
        Caddr = '0; C = '0; Raddr = '0;
    endtask

    task automatic do_clear();
        idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        do_clear();
        Aaddr = 4'd5; Baddr = 4'd5; Daddr = 4'd5;
        #1;
        checks++; if ({a0, b0, d0} !== 48'h0) begin errors++; $display("FAIL reset_ports0 got %h exp 0", {a0, b0, d0}); end
        checks++; if ({ba0, bb0, rc0, bv0} !== 19'h0) begin errors++; $display("FAIL reset_busy0 got %h exp 0", {ba0, bb0, rc0, bv0}); end
        checks++; if ({a1, bv1} !== 32'h0) begin errors++; $display("FAIL reset_inst1 got %h exp 0", {a1, bv1}); end
        load = 1'b1; Caddr = 4'd5; C = 16'hBEEF; reserve = 1'b1; Raddr = 4'd7;
        tick();
        idle();
        #1;
        checks++; if (bv0 !== 16'h0080) begin errors++; $display("FAIL pre_flush_busy got %h exp 0080", bv0); end
        checks++; if (a0 !== 16'hBEEF) begin errors++; $display("FAIL pre_flush_data got %h exp beef", a0); end
        clear = 1'b1; load = 1'b1; Caddr = 4'd5; C = 16'h1357; reserve = 1'b1; Raddr = 4'd3;
        tick();
        idle();
        #1;
        checks++; if ({a0, d0, a1} !== 48'h0) begin errors++; $display("FAIL flush_data got %h exp 0", {a0, d0, a1}); end
        checks++; if ({bv0, bv1} !== 32'h0) begin errors++; $display("FAIL flush_busy got %h exp 0", {bv0, bv1}); end
    endtask

    task automatic test_write_read();
        do_clear();
        load = 1'b1; Caddr = 4'd3; C = 16'h1234; Aaddr = 4'd3; Daddr = 4'd3;
        #1;
        checks++; if (a1 !== 16'h0000) begin errors++; $display("FAIL nobyp_same_cycle got %h exp 0000", a1); end
        checks++; if (d1 !== 16'h0000) begin errors++; $display("FAIL dout_same_cycle got %h exp 0000", d1); end
        checks++; if (a0 !== 16'h1234) begin errors++; $display("FAIL byp_same_cycle got %h exp 1234", a0); end
        tick();
        idle();
        #1;
        checks++; if (a1 !== 16'h1234) begin errors++; $display("FAIL read_after_write got %h exp 1234", a1); end
        checks++; if (d1 !== 16'h1234) begin errors++; $display("FAIL dout_after_write got %h exp 1234", d1); end
    endtask

    task automatic test_bypass();
        do_clear();
        load = 1'b1; Caddr = 4'd9; C = 16'h1111;
        tick();
        idle();
        reserve = 1'b1; Raddr = 4'd9;
        tick();
        idle();
        load = 1'b1; Caddr = 4'd9; C = 16'hA5A5; Aaddr = 4'd9; Baddr = 4'd9; Daddr = 4'd9;
        #1;
        checks++; if ({a0, b0} !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_ab got %h exp a5a5a5a5", {a0, b0}); end
        checks++; if (d0 !== 16'h1111) begin errors++; $display("FAIL bypass_dout got %h exp 1111", d0); end
        checks++; if ({ba0, bb0} !== 2'b00) begin errors++; $display("FAIL bypass_busy got %b exp 00", {ba0, bb0}); end
        checks++; if ({a1, ba1, bb1} !== {16'h1111, 2'b11}) begin errors++; $display("FAIL nobypass_inst1 got %h exp 1111/11", {a1, ba1, bb1}); end
        tick();
        idle();
        #1;
        checks++; if ({bv0[9], a0} !== {1'b0, 16'hA5A5}) begin errors++; $display("FAIL bypass_after got %h exp 0a5a5", {bv0[9], a0}); end
    endtask

    task automatic test_zero_reg();
        do_clear();
        load = 1'b1; Caddr = 4'd0; C = 16'hFFFF; reserve = 1'b1; Raddr = 4'd0;
        Aaddr = 4'd0; Baddr = 4'd0; Daddr = 4'd0;
        #1;
        checks++; if ({a1, b1, rc1} !== 33'h0) begin errors++; $display("FAIL zero_same_cycle got %h exp 0", {a1, b1, rc1}); end
        checks++; if ({a0, rc0} !== {16'hFFFF, 1'b0}) begin errors++; $display("FAIL reg0_plain_byp got %h exp 1fffe", {a0, rc0}); end
        tick();
        idle();
        #1;
        checks++; if ({a1, d1, bv1[0]} !== 33'h0) begin errors++; $display("FAIL zero_after got %h exp 0", {a1, d1, bv1[0]}); end
        checks++; if ({d0, bv0[0]} !== {16'hFFFF, 1'b1}) begin errors++; $display("FAIL reg0_plain_after got %h exp 1ffff", {d0, bv0[0]}); end
        reserve = 1'b1; Raddr = 4'd0;
        #1;
        checks++; if ({rc0, rc1} !== 2'b10) begin errors++; $display("FAIL reg0_conflict got %b exp 10", {rc0, rc1}); end
        tick();
        idle();
    endtask

    task automatic test_scoreboard();
        do_clear();
        reserve = 1'b1; Raddr = 4'd4;
        #1;
        checks++; if ({rc0, rc1} !== 2'b00) begin errors++; $display("FAIL first_reserve_conflict got %b exp 00", {rc0, rc1}); end
        tick();
        Aaddr = 4'd4;
        #1;
        checks++; if ({bv0, bv1} !== 32'h00100010) begin errors++; $display("FAIL reserve_vec got %h exp 00100010", {bv0, bv1}); end
        checks++; if ({rc0, rc1, ba0, ba1} !== 4'b1111) begin errors++; $display("FAIL rereserve got %b exp 1111", {rc0, rc1, ba0, ba1}); end
        tick();
        idle();
        #1;
        checks++; if (bv0 !== 16'h0010) begin errors++; $display("FAIL rereserve_vec got %h exp 0010", bv0); end
        load = 1'b1; Caddr = 4'd4; C = 16'h0042;
        tick();
        idle();
        #1;
        checks++; if ({bv0, bv1} !== 32'h0) begin errors++; $display("FAIL writeback_vec got %h exp 0", {bv0, bv1}); end
        checks++; if ({a0, a1} !== 32'h00420042) begin errors++; $display("FAIL writeback_data got %h exp 00420042", {a0, a1}); end
    endtask

    task automatic test_simultaneous();
        do_clear();
        load = 1'b1; Caddr = 4'd6; C = 16'h0777; reserve = 1'b1; Raddr = 4'd6; Daddr = 4'd6;
        #1;
        checks++; if ({rc0, rc1} !== 2'b00) begin errors++; $display("FAIL simul_free_conflict got %b exp 00", {rc0, rc1}); end
        tick();
        idle();
        #1;
        checks++; if ({d0, d1} !== 32'h07770777) begin errors++; $display("FAIL simul_free_data got %h exp 07770777", {d0, d1}); end
        checks++; if ({bv0, bv1} !== 32'h00400040) begin errors++; $display("FAIL simul_free_vec got %h exp 00400040", {bv0, bv1}); end
        load = 1'b1; Caddr = 4'd6; C = 16'h0888; reserve = 1'b1; Raddr = 4'd6;
        #1;
        checks++; if ({rc0, rc1} !== 2'b11) begin errors++; $display("FAIL simul_busy_conflict got %b exp 11", {rc0, rc1}); end
        tick();
        idle();
        #1;
        checks++; if ({bv0, bv1, d0} !== {32'h0, 16'h0888}) begin errors++; $display("FAIL simul_busy_after got %h exp 0888", {bv0, bv1, d0}); end
    endtask

    task automatic test_random();
        logic [66:0] got0, got1, exp0, exp1;
        int          bad = 0;
        do_clear();
        for (int n = 0; n < 400; n++) begin
            clear   = ($urandom_range(0, 49) == 0);
            load    = $urandom_range(0, 1);
            reserve = $urandom_range(0, 1);
            Caddr   = 4'($urandom_range(0, 15));
            Raddr   = ($urandom_range(0, 3) == 0) ? Caddr : 4'($urandom_range(0, 15));
            Aaddr   = ($urandom_range(0, 3) == 0) ? Caddr : 4'($urandom_range(0, 15));
            Baddr   = ($urandom_range(0, 3) == 0) ? Caddr : 4'($urandom_range(0, 15));
            Daddr   = 4'($urandom_range(0, 15));
            C       = 16'($urandom);
            #1;
            got0 = {a0, b0, d0, ba0, bb0, rc0, bv0};
            got1 = {a1, b1, d1, ba1, bb1, rc1, bv1};
            exp0 = m_exp(0);
            exp1 = m_exp(1);
            checks++;
            if (got0 !== exp0) begin
                errors++;
                if (bad < 10) $display("FAIL random_inst0 cycle %0d got %h exp %h", n, got0, exp0);
                bad++;
            end
            checks++;
            if (got1 !== exp1) begin
                errors++;
                if (bad < 10) $display("FAIL random_inst1 cycle %0d got %h exp %h", n, got1, exp1);
                bad++;
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        Aaddr = '0; Baddr = '0; Daddr = '0;
        #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
